// File: rtl/fp_round_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_round_pipe_if
//  Purpose  : Input/output handshake bundle of the fp_round_pipe stage.
//  Revision : 1.0  initial release
// ============================================================================
interface fp_round_pipe_if #(
    parameter int EW   = 8,
    parameter int FW   = 23,
    parameter int TAGW = 4
);
    localparam int FPWID = 1 + EW + FW;

    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_rm;
    logic [FPWID+2:0]   in_i;
    logic [TAGW-1:0]    in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [FPWID-1:0]   out_o;
    logic [TAGW-1:0]    out_tag;
    logic               out_nx;
    logic               out_of;
    logic               out_uf;

    modport master (
        output in_valid, in_rm, in_i, in_tag, out_ready,
        input  in_ready, out_valid, out_o, out_tag, out_nx, out_of, out_uf
    );

    modport slave (
        input  in_valid, in_rm, in_i, in_tag, out_ready,
        output in_ready, out_valid, out_o, out_tag, out_nx, out_of, out_uf
    );
endinterface
`default_nettype wire

// File: rtl/fp_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_round_pipe
//  Purpose  : Three-stage handshaked IEEE-754 rounding stage with flags.
//  Revision : 1.0  initial release
// ============================================================================
module fp_round_pipe #(
    parameter int EW   = 8,
    parameter int FW   = 23,
    parameter int TAGW = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clr,
    fp_round_pipe_if.slave    bus
);
    localparam int            FPWID    = 1 + EW + FW;
    localparam int            MW       = EW + FW;
    localparam logic [EW-1:0] EXP_ONES = '1;

    // ---------------- input field split ----------------
    logic          w_sign;
    logic [EW-1:0] w_exp;
    logic [FW-1:0] w_frac;
    logic          w_r;
    logic          w_s;
    logic          w_inc;
    logic          w_unused_hidden;

    assign w_sign          = bus.in_i[FPWID+2];
    assign w_exp           = bus.in_i[FPWID+1 -: EW];
    assign w_unused_hidden = bus.in_i[FW+2];
    assign w_frac          = bus.in_i[FW+1 -: FW];
    assign w_r             = bus.in_i[1];
    assign w_s             = bus.in_i[0];

    always_comb begin
        case (bus.in_rm)
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = (w_r | w_s) & ~w_sign;
            3'd3:    w_inc = (w_r | w_s) & w_sign;
            3'd4:    w_inc = w_r;
            default: w_inc = w_r & (w_s | w_frac[0]);
        endcase
        if (w_exp == EXP_ONES) begin
            w_inc = 1'b0;
        end
    end

    // ---------------- handshake ----------------
    logic r_v1, r_v2, r_v3;
    logic w_adv1, w_adv2, w_adv3;

    assign w_adv3       = ~r_v3 | bus.out_ready;
    assign w_adv2       = ~r_v2 | w_adv3;
    assign w_adv1       = ~r_v1 | w_adv2;
    assign bus.in_ready = w_adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (clr) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= bus.in_valid;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;
        end
    end

    // ---------------- stage 1: fields and increment decision ----------------
    logic            r_sign1;
    logic [EW-1:0]   r_exp1;
    logic [FW-1:0]   r_frac1;
    logic            r_rs1;
    logic            r_inc1;
    logic [TAGW-1:0] r_tag1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign1 <= 1'b0;
            r_exp1  <= '0;
            r_frac1 <= '0;
            r_rs1   <= 1'b0;
            r_inc1  <= 1'b0;
            r_tag1  <= '0;
        end else if (w_adv1) begin
            r_sign1 <= w_sign;
            r_exp1  <= w_exp;
            r_frac1 <= w_frac;
            r_rs1   <= w_r | w_s;
            r_inc1  <= w_inc;
            r_tag1  <= bus.in_tag;
        end
    end

    // ---------------- stage 2: magnitude increment ----------------
    // Adding across {exp,frac} lets a fraction carry bump the exponent, which
    // covers both denormal->normal and max-finite->Inf without a shifter.
    logic [MW-1:0]   w_sum;
    logic            r_sign2;
    logic [MW-1:0]   r_sum2;
    logic            r_rs2;
    logic            r_special2;
    logic [TAGW-1:0] r_tag2;

    assign w_sum = {r_exp1, r_frac1} + {{(MW-1){1'b0}}, r_inc1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign2    <= 1'b0;
            r_sum2     <= '0;
            r_rs2      <= 1'b0;
            r_special2 <= 1'b0;
            r_tag2     <= '0;
        end else if (w_adv2) begin
            r_sign2    <= r_sign1;
            r_sum2     <= w_sum;
            r_rs2      <= r_rs1;
            r_special2 <= (r_exp1 == EXP_ONES);
            r_tag2     <= r_tag1;
        end
    end

    logic w_nx, w_of, w_uf;
    assign w_nx = r_rs2 & ~r_special2;
    assign w_of = (r_sum2[MW-1 -: EW] == EXP_ONES) & ~r_special2;
    assign w_uf = (r_sum2[MW-1 -: EW] == '0) & w_nx;

    // ---------------- stage 3: output register ----------------
    logic [FPWID-1:0] r_o;
    logic [TAGW-1:0]  r_tag3;
    logic             r_nx, r_of, r_uf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o    <= '0;
            r_tag3 <= '0;
            r_nx   <= 1'b0;
            r_of   <= 1'b0;
            r_uf   <= 1'b0;
        end else if (w_adv3) begin
            r_o    <= {r_sign2, r_sum2};
            r_tag3 <= r_tag2;
            r_nx   <= w_nx;
            r_of   <= w_of;
            r_uf   <= w_uf;
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.out_o     = r_o;
    assign bus.out_tag   = r_tag3;
    assign bus.out_nx    = r_nx;
    assign bus.out_of    = r_of;
    assign bus.out_uf    = r_uf;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_round_pipe
//  Purpose  : Self-checking bench for fp_round_pipe (EW=8, FW=23, TAGW=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_round_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    fp_round_pipe_if #(.EW(8), .FW(23), .TAGW(4)) bus ();

    fp_round_pipe #(.EW(8), .FW(23), .TAGW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] o;
        logic        nx;
        logic        ovf;
        logic        uf;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   out_cnt  = 0;
    exp_t sbq[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Reference: treat {exp,frac} as an integer magnitude, add one ulp when the
    // mode says so, and read the flags off the resulting exponent.
    function automatic logic [34:0] ref_round(input logic [34:0] w, input logic [2:0] rm);
        logic        sgn;
        logic [7:0]  e;
        logic [22:0] f;
        logic        r, s, up;
        longint      mag;
        longint      re;
        sgn = w[34];
        e   = w[33:26];
        f   = w[24:2];
        r   = w[1];
        s   = w[0];
        if (e == 8'hFF) return {sgn, e, f, 3'b000};
        mag = longint'({e, f});
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = (r | s) & ~sgn;
            3'd3:    up = (r | s) & sgn;
            3'd4:    up = r;
            default: up = r & (s | ((mag % 2) == 1));
        endcase
        mag = mag + longint'(up);
        re  = mag / (longint'(1) << 23);
        return {sgn, 31'(mag), r | s, re == 255, (re == 0) && (r | s)};
    endfunction

    function automatic logic [34:0] rand_word();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFE;
            2:       e = 8'hFF;
            3:       e = 8'h7F;
            default: e = 8'($urandom);
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        return {1'($urandom), e, 1'($urandom), f, 2'($urandom)};
    endfunction

    // Scoreboard: push on accepted input, pop and compare on delivered output,
    // and require a stalled output to hold its value.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_o;
    logic [3:0]  prev_tag;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && bus.out_valid) begin
                check_val("hold_o", bus.out_o, prev_o);
                check_val("hold_tag", bus.out_tag, prev_tag);
            end
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                if (sbq.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check_val("out_tag", bus.out_tag, mon_e.tag);
                    check_val("out_o", bus.out_o, mon_e.o);
                    check_val("out_flags", {bus.out_nx, bus.out_of, bus.out_uf},
                              {mon_e.nx, mon_e.ovf, mon_e.uf});
                end
            end
            if (bus.in_valid && bus.in_ready && !clr)
                sbq.push_back(exp_t'({bus.in_tag, ref_round(bus.in_i, bus.in_rm)}));
            prev_stall = bus.out_valid && !bus.out_ready && !clr;
            prev_o     = bus.out_o;
            prev_tag   = bus.out_tag;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_one(input string name, input logic sgn, input logic [7:0] e,
                           input logic [22:0] f, input logic r, input logic s,
                           input logic [2:0] rm, input logic [31:0] exp_o,
                           input logic [2:0] exp_flags);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_i      = {sgn, e, e != 8'h00, f, r, s};
        bus.in_rm     = rm;
        bus.in_tag    = 4'($urandom);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val({name, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check_val({name, "_latency"}, n, 3);
        check_val({name, "_o"}, bus.out_o, exp_o);
        check_val({name, "_flags"}, {bus.out_nx, bus.out_of, bus.out_uf}, exp_flags);
        @(posedge clk);
        #1;
    endtask

    logic [34:0] pl  [8];
    logic [2:0]  plrm[8];

    initial begin
        int  ti, base, n_sent;
        bit  saw, any_v, acc;

        bus.in_valid  = 1'b0;
        bus.in_rm     = 3'd0;
        bus.in_i      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_o", bus.out_o, 0);
        check_val("rst_out_tag_flags", {bus.out_tag, bus.out_nx, bus.out_of, bus.out_uf}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed rounding cases
        run_one("tie_even",  1'b0, 8'h7F, 23'h000000, 1'b1, 1'b0, 3'd0, 32'h3F800000, 3'b100);
        run_one("tie_odd",   1'b0, 8'h7F, 23'h000001, 1'b1, 1'b0, 3'd0, 32'h3F800002, 3'b100);
        run_one("ovf_rne",   1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1, 3'd0, 32'h7F800000, 3'b110);
        run_one("ovf_rtz",   1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1, 3'd1, 32'h7F7FFFFF, 3'b100);
        run_one("den_rup",   1'b0, 8'h00, 23'h7FFFFF, 1'b0, 1'b1, 3'd2, 32'h00800000, 3'b100);
        run_one("den_rdn",   1'b0, 8'h00, 23'h7FFFFF, 1'b0, 1'b1, 3'd3, 32'h007FFFFF, 3'b101);
        run_one("nan_rup",   1'b0, 8'hFF, 23'h400001, 1'b1, 1'b1, 3'd2, 32'h7FC00001, 3'b000);
        run_one("nan_rmm",   1'b0, 8'hFF, 23'h400001, 1'b1, 1'b1, 3'd4, 32'h7FC00001, 3'b000);
        run_one("rm5_rne",   1'b0, 8'h7F, 23'h000001, 1'b1, 1'b0, 3'd5, 32'h3F800002, 3'b100);
        run_one("neg_rdn",   1'b1, 8'h80, 23'h000000, 1'b1, 1'b0, 3'd3, 32'hC0000001, 3'b100);
        run_one("rmm_tie",   1'b1, 8'h7F, 23'h000000, 1'b1, 1'b0, 3'd4, 32'hBF800001, 3'b100);

        // Back-to-back tags 0..7 with a 5-cycle output stall
        for (int k = 0; k < 8; k++) begin
            pl[k]   = rand_word();
            plrm[k] = 3'($urandom_range(0, 7));
        end
        base = out_cnt;
        ti   = 0;
        saw  = 1'b0;
        for (int c = 0; c < 60 && !(ti == 8 && out_cnt == base + 8); c++) begin
            bus.out_ready = !(c >= 5 && c <= 9);
            bus.in_valid  = (ti < 8);
            if (ti < 8) begin
                bus.in_i   = pl[ti];
                bus.in_rm  = plrm[ti];
                bus.in_tag = 4'(ti);
            end
            @(negedge clk);
            if (!bus.in_ready) saw = 1'b1;
            if (bus.in_valid && bus.in_ready) ti++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check_val("bb_in_ready_low", saw, 1);
        check_val("bb_sent", ti, 8);
        check_val("bb_delivered", out_cnt - base, 8);

        // Randomised traffic against the reference model
        n_sent = 0;
        acc    = 1'b0;
        for (int c = 0; c < 5000 && (n_sent < 300 || sbq.size() != 0); c++) begin
            if (!bus.in_valid && n_sent < 300 && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_i     = rand_word();
                bus.in_rm    = 3'($urandom_range(0, 7));
                bus.in_tag   = 4'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) n_sent++;
            @(posedge clk);
            #1;
            if (acc) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        check_val("rand_sent", n_sent, 300);
        check_val("rand_drained", sbq.size(), 0);

        // Asynchronous reset with three results in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_i     = rand_word();
            bus.in_rm    = 3'd0;
            bus.in_tag   = 4'(k + 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_out_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_out_valid", bus.out_valid, 0);
        check_val("async_rst_out_o", bus.out_o, 0);
        check_val("async_rst_tag_flags", {bus.out_tag, bus.out_nx, bus.out_of, bus.out_uf}, 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("post_rst_in_ready", bus.in_ready, 1);
        base  = out_cnt;
        any_v = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) any_v = 1'b1;
        end
        check_val("post_rst_no_result", any_v, 0);
        check_val("post_rst_out_cnt", out_cnt - base, 0);

        // Synchronous clear with two in flight, also dropping a same-cycle input
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_i     = rand_word();
            bus.in_tag   = 4'(k + 9);
            @(posedge clk);
            #1;
        end
        bus.in_tag = 4'd11;
        clr        = 1'b1;
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_val("clr_out_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        any_v = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) any_v = 1'b1;
        end
        check_val("clr_no_result", any_v, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
